hazard_ctrl: RTL and testbench

Pipeline hazard controller for the five-stage RV32I core. Keeps its own scoreboard of the instructions in EX, MEM and WB, built from the decode-stage control signals (rd, rf_we, load flag, rs read-enables). From that scoreboard it drives rs1/rs2 forwarding selects, the load-use stall, and the IF/ID and ID/EX flushes on a taken branch or jump. Also keeps saturating stall and flush event counters for trace and debug.

---
 rtl/hazard_ctrl.sv | 138 +++++++++++++
 tb/tb_hazard_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Hazard controller for the five-stage RV32I pipeline: keeps a private EX/MEM/WB
// scoreboard and derives forwarding selects, the load-use stall and redirect flushes.
module hazard_ctrl #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             cpu_clk,
  input  logic             cpu_rst,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_re1,
  input  logic             id_re2,
  input  logic [4:0]       id_rd,
  input  logic             id_rf_we,
  input  logic             id_is_load,
  input  logic             ex_redirect,
  output logic             stall_pc,
  output logic             stall_if_id,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic [1:0]       fwd_rs1_sel,
  output logic [1:0]       fwd_rs2_sel,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef struct packed {
    logic       v;
    logic [4:0] rd;
    logic       we;
    logic       ld;
  } sb_ent_t;

  localparam logic [1:0] SelRf  = 2'b00;
  localparam logic [1:0] SelEx  = 2'b01;
  localparam logic [1:0] SelMem = 2'b10;
  localparam logic [1:0] SelWb  = 2'b11;

  sb_ent_t ex_q, mem_q, wb_q;
  sb_ent_t ex_d;

  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic ex_wr, mem_wr, wb_wr;
  logic load_use;
  logic stall_evt;

  function automatic logic [1:0] fwd_sel(
    input logic [4:0] rs,
    input logic       re,
    input sb_ent_t    ex,
    input logic       ex_w,
    input sb_ent_t    mem,
    input logic       mem_w,
    input sb_ent_t    wb,
    input logic       wb_w
  );
    logic [1:0] sel;
    sel = SelRf;
    if (re) begin
      // Youngest producer wins; a load still in EX has no data to forward yet.
      if (ex_w && !ex.ld && ex.rd == rs) begin
        sel = SelEx;
      end else if (mem_w && mem.rd == rs) begin
        sel = SelMem;
      end else if (wb_w && wb.rd == rs) begin
        sel = SelWb;
      end
    end
    return sel;
  endfunction

  always_comb begin
    ex_wr  = ex_q.v && ex_q.we && (ex_q.rd != 5'd0);
    mem_wr = mem_q.v && mem_q.we && (mem_q.rd != 5'd0);
    wb_wr  = wb_q.v && wb_q.we && (wb_q.rd != 5'd0);

    load_use = id_valid && ex_wr && ex_q.ld &&
               ((id_re1 && id_rs1 == ex_q.rd) || (id_re2 && id_rs2 == ex_q.rd));
    stall_evt = load_use && !ex_redirect;
  end

  // All hazard outputs are held low while in reset.
  always_comb begin
    stall_pc    = 1'b0;
    stall_if_id = 1'b0;
    flush_if_id = 1'b0;
    flush_id_ex = 1'b0;
    fwd_rs1_sel = SelRf;
    fwd_rs2_sel = SelRf;
    if (!cpu_rst) begin
      stall_pc    = stall_evt;
      stall_if_id = stall_evt;
      flush_if_id = ex_redirect;
      flush_id_ex = ex_redirect || load_use;
      fwd_rs1_sel = fwd_sel(id_rs1, id_re1, ex_q, ex_wr, mem_q, mem_wr, wb_q, wb_wr);
      fwd_rs2_sel = fwd_sel(id_rs2, id_re2, ex_q, ex_wr, mem_q, mem_wr, wb_q, wb_wr);
    end
  end

  always_comb begin
    ex_d = '{v: id_valid, rd: id_rd, we: id_rf_we, ld: id_is_load};
    if (flush_id_ex) begin
      ex_d = '0;
    end

    stall_cnt_d = stall_cnt_q;
    if (stall_evt && stall_cnt_q != {CNT_W{1'b1}}) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end

    flush_cnt_d = flush_cnt_q;
    if (ex_redirect && flush_cnt_q != {CNT_W{1'b1}}) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      ex_q        <= ex_d;
      mem_q       <= ex_q;
      wb_q        <= mem_q;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed pipeline scenarios plus random traffic, all checked
// against an instruction-level model of the EX/MEM/WB occupancy.
module tb_hazard_ctrl;

  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          cpu_clk;
  logic          cpu_rst;
  logic          id_valid;
  logic [4:0]    id_rs1, id_rs2, id_rd;
  logic          id_re1, id_re2, id_rf_we, id_is_load;
  logic          ex_redirect;
  logic          stall_pc, stall_if_id, flush_if_id, flush_id_ex;
  logic [1:0]    fwd_rs1_sel, fwd_rs2_sel;
  logic [CW-1:0] stall_cnt, flush_cnt;

  hazard_ctrl #(.CNT_W(CW)) dut (
    .cpu_clk     (cpu_clk),
    .cpu_rst     (cpu_rst),
    .id_valid    (id_valid),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_re1      (id_re1),
    .id_re2      (id_re2),
    .id_rd       (id_rd),
    .id_rf_we    (id_rf_we),
    .id_is_load  (id_is_load),
    .ex_redirect (ex_redirect),
    .stall_pc    (stall_pc),
    .stall_if_id (stall_if_id),
    .flush_if_id (flush_if_id),
    .flush_id_ex (flush_id_ex),
    .fwd_rs1_sel (fwd_rs1_sel),
    .fwd_rs2_sel (fwd_rs2_sel),
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt)
  );

  initial cpu_clk = 1'b0;
  always #5 cpu_clk = ~cpu_clk;

  // Model: the instructions currently occupying EX (0), MEM (1) and WB (2).
  typedef struct {
    bit     v;
    int     rd;
    bit     we;
    bit     ld;
  } instr_t;

  instr_t pipe[3];
  int     m_stall;
  int     m_flush;
  int     checks;
  int     failures;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit produces(input instr_t e);
    return e.v && e.we && e.rd != 0;
  endfunction

  function automatic int model_sel(input int rs, input bit re);
    if (!re) return 0;
    for (int k = 0; k < 3; k++) begin
      if (produces(pipe[k]) && pipe[k].rd == rs && !(k == 0 && pipe[k].ld)) return k + 1;
    end
    return 0;
  endfunction

  function automatic bit model_load_use();
    if (!id_valid || !produces(pipe[0]) || !pipe[0].ld) return 0;
    return (id_re1 && int'(id_rs1) == pipe[0].rd) || (id_re2 && int'(id_rs2) == pipe[0].rd);
  endfunction

  task automatic check_model();
    bit lu, rd;
    lu = model_load_use();
    rd = ex_redirect;
    if (cpu_rst) begin
      chk("rst_stall_pc", 32'(stall_pc), 0);
      chk("rst_stall_if_id", 32'(stall_if_id), 0);
      chk("rst_flush_if_id", 32'(flush_if_id), 0);
      chk("rst_flush_id_ex", 32'(flush_id_ex), 0);
      chk("rst_fwd1", 32'(fwd_rs1_sel), 0);
      chk("rst_fwd2", 32'(fwd_rs2_sel), 0);
    end else begin
      chk("stall_pc", 32'(stall_pc), 32'(lu && !rd));
      chk("stall_if_id", 32'(stall_if_id), 32'(lu && !rd));
      chk("flush_if_id", 32'(flush_if_id), 32'(rd));
      chk("flush_id_ex", 32'(flush_id_ex), 32'(lu || rd));
      chk("fwd1", 32'(fwd_rs1_sel), 32'(model_sel(int'(id_rs1), id_re1)));
      chk("fwd2", 32'(fwd_rs2_sel), 32'(model_sel(int'(id_rs2), id_re2)));
    end
    chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
    chk("flush_cnt", 32'(flush_cnt), 32'(m_flush));
  endtask

  task automatic drive(input bit rst, input bit v, input int rs1, input int rs2,
                       input bit re1, input bit re2, input int rd, input bit we,
                       input bit ld, input bit redir);
    cpu_rst     = rst;
    id_valid    = v;
    id_rs1      = 5'(rs1);
    id_rs2      = 5'(rs2);
    id_re1      = re1;
    id_re2      = re2;
    id_rd       = 5'(rd);
    id_rf_we    = we;
    id_is_load  = ld;
    ex_redirect = redir;
    #1;
    check_model();
  endtask

  task automatic tick();
    bit     rst, lu, redir;
    instr_t nxt;
    rst   = cpu_rst;
    lu    = model_load_use();
    redir = ex_redirect;
    nxt   = '{v: id_valid, rd: int'(id_rd), we: id_rf_we, ld: id_is_load};
    @(posedge cpu_clk);
    if (rst) begin
      for (int k = 0; k < 3; k++) pipe[k] = '{v: 0, rd: 0, we: 0, ld: 0};
      m_stall = 0;
      m_flush = 0;
    end else begin
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = (lu || redir) ? '{v: 0, rd: 0, we: 0, ld: 0} : nxt;
      if (lu && !redir && m_stall < CMAX) m_stall++;
      if (redir && m_flush < CMAX) m_flush++;
    end
    @(negedge cpu_clk);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    m_stall  = 0;
    m_flush  = 0;
    for (int k = 0; k < 3; k++) pipe[k] = '{v: 0, rd: 0, we: 0, ld: 0};

    // Clear power-up X before the first checked cycle.
    cpu_rst = 1'b1; id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_re1 = 0; id_re2 = 0;
    id_rd = 0; id_rf_we = 0; id_is_load = 0; ex_redirect = 0;
    @(posedge cpu_clk);
    @(negedge cpu_clk);

    // Reset held with random inputs
    for (int i = 0; i < 2; i++) begin
      drive(1, 1'($urandom), $urandom_range(0, 31), $urandom_range(0, 31), 1'($urandom),
            1'($urandom), $urandom_range(0, 31), 1'($urandom), 1'($urandom), 1'($urandom));
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("post_rst_stall_cnt", 32'(stall_cnt), 0);
    tick();

    // ALU chain: add x5,x1,x2 / sub x6,x5,x3 / or x7,x5,x6
    drive(0, 1, 1, 2, 1, 1, 5, 1, 0, 0);
    tick();
    drive(0, 1, 5, 3, 1, 1, 6, 1, 0, 0);
    chk("alu_sub_fwd1_ex", 32'(fwd_rs1_sel), 1);
    tick();
    drive(0, 1, 5, 6, 1, 1, 7, 1, 0, 0);
    chk("alu_or_fwd1_mem", 32'(fwd_rs1_sel), 2);
    chk("alu_or_fwd2_ex", 32'(fwd_rs2_sel), 1);
    chk("alu_no_stall", 32'(stall_pc), 0);
    tick();

    // Load-use: lw x8,0(x1) / add x9,x8,x8
    drive(0, 1, 1, 0, 1, 0, 8, 1, 1, 0);
    tick();
    drive(0, 1, 8, 8, 1, 1, 9, 1, 0, 0);
    chk("lu_stall_pc", 32'(stall_pc), 1);
    chk("lu_flush_id_ex", 32'(flush_id_ex), 1);
    tick();
    drive(0, 1, 8, 8, 1, 1, 9, 1, 0, 0);
    chk("lu_after_fwd1", 32'(fwd_rs1_sel), 2);
    chk("lu_after_fwd2", 32'(fwd_rs2_sel), 2);
    chk("lu_after_no_stall", 32'(stall_pc), 0);
    chk("lu_stall_cnt", 32'(stall_cnt), 1);
    tick();

    // x0 producer never forwards; lui x4 (no reads) never stalls on a load of x4
    drive(0, 1, 1, 2, 1, 1, 0, 1, 0, 0);
    tick();
    drive(0, 1, 0, 0, 1, 1, 3, 1, 0, 0);
    chk("x0_fwd1", 32'(fwd_rs1_sel), 0);
    chk("x0_fwd2", 32'(fwd_rs2_sel), 0);
    tick();
    drive(0, 1, 1, 0, 1, 0, 4, 1, 1, 0);
    tick();
    drive(0, 1, 4, 4, 0, 0, 4, 1, 0, 0);
    chk("lui_fwd1", 32'(fwd_rs1_sel), 0);
    chk("lui_fwd2", 32'(fwd_rs2_sel), 0);
    chk("lui_no_stall", 32'(stall_pc), 0);
    tick();

    // Redirect beats load-use; the flushed consumer (rd x11) never reaches EX
    drive(0, 1, 1, 0, 1, 0, 10, 1, 1, 0);
    tick();
    drive(0, 1, 10, 0, 1, 0, 11, 1, 0, 1);
    chk("redir_flush_if_id", 32'(flush_if_id), 1);
    chk("redir_flush_id_ex", 32'(flush_id_ex), 1);
    chk("redir_no_stall", 32'(stall_pc), 0);
    tick();
    drive(0, 1, 11, 10, 1, 1, 12, 1, 0, 0);
    chk("redir_bubble_fwd1", 32'(fwd_rs1_sel), 0);
    chk("redir_load_mem_fwd2", 32'(fwd_rs2_sel), 2);
    chk("redir_stall_cnt", 32'(stall_cnt), 1);
    chk("redir_flush_cnt", 32'(flush_cnt), 1);
    tick();

    // Random traffic over a small register window to provoke hazards
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 63) == 0, 1'($urandom), $urandom_range(0, 7),
            $urandom_range(0, 7), 1'($urandom), 1'($urandom), $urandom_range(0, 7),
            $urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 7) == 0);
      tick();
    end

    // Saturation: 20 redirects on a 4-bit counter, then reset clears it
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    for (int i = 0; i < 20; i++) begin
      drive(0, 1, $urandom_range(0, 31), $urandom_range(0, 31), 1, 1,
            $urandom_range(0, 31), 1, 1'($urandom), 1);
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("sat_flush_cnt", 32'(flush_cnt), 15);
    drive(1, 1, 3, 3, 1, 1, 3, 1, 1, 1);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("sat_rst_flush_cnt", 32'(flush_cnt), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
